// File: rtl/loader_pkg.sv
// Shared types and command constants for the UART-fed program loader.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX_HI = 2'd1,
    ST_RX_LO = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_t;

  localparam logic [7:0]  CMD_START  = 8'hA5;
  localparam logic [7:0]  CMD_RELOAD = 8'hC3;
  localparam logic [15:0] HALT_WORD  = 16'h0000;

endpackage

// File: rtl/program_ram.sv
// Instruction store: one synchronous write port, one registered read port,
// read-before-write when both ports hit the same address.
module program_ram #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately left untouched by reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) o_rdata <= '0;
    else         o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/program_loader.sv
// Loads 16-bit instruction words from a UART byte stream into program RAM and
// holds the CPU in reset until a HALT-terminated (or memory-filling) load ends.
//
// state    | meaning
// ST_IDLE  | no program loaded, waiting for CMD_START
// ST_RX_HI | waiting for the high byte of the next word
// ST_RX_LO | waiting for the low byte; word is written on arrival
// ST_RUN   | program loaded, CPU released, waiting for CMD_RELOAD
module program_loader
  import loader_pkg::*;
#(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_RxData,
  input  logic               i_RxValid,
  input  logic [NBITS_0-1:0] i_Addr,
  output logic [NBITS_D-1:0] o_Instruction,
  output logic               o_CpuReset,
  output logic               o_Running,
  output logic [NBITS_0:0]   o_WordCount,
  output logic               o_Overflow
);

  loader_state_t      state;
  logic [NBITS_0-1:0] ptr;
  logic [7:0]         hi_byte;
  logic               wr_en;
  logic [NBITS_D-1:0] wr_data;
  logic               is_halt;
  logic               at_last;

  assign wr_en   = (state == ST_RX_LO) && i_RxValid;
  assign wr_data = NBITS_D'({hi_byte, i_RxData});
  assign is_halt = (wr_data == NBITS_D'(HALT_WORD));
  assign at_last = &ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hi_byte     <= '0;
      o_WordCount <= '0;
      o_Overflow  <= 1'b0;
    end else if (i_RxValid) begin
      case (state)
        ST_IDLE: begin
          if (i_RxData == CMD_START) begin
            state       <= ST_RX_HI;
            ptr         <= '0;
            o_WordCount <= '0;
            o_Overflow  <= 1'b0;
          end
        end
        ST_RX_HI: begin
          hi_byte <= i_RxData;
          state   <= ST_RX_LO;
        end
        ST_RX_LO: begin
          o_WordCount <= {1'b0, ptr} + 1'b1;
          // HALT wins over a full memory, so a HALT in the last slot is clean.
          if (is_halt) begin
            state <= ST_RUN;
          end else if (at_last) begin
            state      <= ST_RUN;
            o_Overflow <= 1'b1;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= ST_RX_HI;
          end
        end
        ST_RUN: begin
          if (i_RxData == CMD_RELOAD) begin
            state       <= ST_RX_HI;
            ptr         <= '0;
            o_WordCount <= '0;
            o_Overflow  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_CpuReset = (state != ST_RUN);
  assign o_Running  = (state == ST_RUN);

  program_ram #(
    .AW(NBITS_0),
    .DW(NBITS_D)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (wr_en),
    .i_waddr (ptr),
    .i_wdata (wr_data),
    .i_raddr (i_Addr),
    .o_rdata (o_Instruction)
  );

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; a byte-level behavioural
// model predicts status outputs and memory contents for two RAM depths.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data_b = '0, rx_data_s = '0;
  logic        rx_valid_b = 1'b0, rx_valid_s = 1'b0;
  logic [10:0] addr_b = '0;
  logic [1:0]  addr_s = '0;
  logic [15:0] instr_b, instr_s;
  logic        cpurst_b, cpurst_s, run_b, run_s, ovf_b, ovf_s;
  logic [11:0] wc_b;
  logic [2:0]  wc_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  program_loader dut_b (
    .i_clk(clk), .i_reset(rst), .i_RxData(rx_data_b), .i_RxValid(rx_valid_b),
    .i_Addr(addr_b), .o_Instruction(instr_b), .o_CpuReset(cpurst_b),
    .o_Running(run_b), .o_WordCount(wc_b), .o_Overflow(ovf_b)
  );

  program_loader #(.NBITS_0(2)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_RxData(rx_data_s), .i_RxValid(rx_valid_s),
    .i_Addr(addr_s), .o_Instruction(instr_s), .o_CpuReset(cpurst_s),
    .o_Running(run_s), .o_WordCount(wc_s), .o_Overflow(ovf_s)
  );

  // Behavioural model, index 0 = 2048-word DUT, index 1 = 4-word DUT.
  int          m_depth [2] = '{2048, 4};
  logic [15:0] m_mem   [2][2048];
  bit          m_loading [2], m_have_hi [2], m_running [2], m_ovf [2];
  logic [7:0]  m_hi [2];
  int          m_ptr [2], m_count [2];

  task automatic model_reset(input int s);
    m_loading[s] = 0; m_have_hi[s] = 0; m_running[s] = 0;
    m_ovf[s] = 0; m_ptr[s] = 0; m_count[s] = 0;
  endtask

  task automatic model_byte(input int s, input logic [7:0] b);
    logic [15:0] w;
    if (m_loading[s]) begin
      if (!m_have_hi[s]) begin
        m_hi[s] = b; m_have_hi[s] = 1;
      end else begin
        w = {m_hi[s], b};
        m_have_hi[s] = 0;
        m_mem[s][m_ptr[s]] = w;
        m_count[s] = m_ptr[s] + 1;
        if (w == 16'h0000) begin
          m_loading[s] = 0; m_running[s] = 1;
        end else if (m_ptr[s] == m_depth[s] - 1) begin
          m_loading[s] = 0; m_running[s] = 1; m_ovf[s] = 1;
        end else begin
          m_ptr[s] = m_ptr[s] + 1;
        end
      end
    end else if ((!m_running[s] && b == 8'hA5) || (m_running[s] && b == 8'hC3)) begin
      m_loading[s] = 1; m_running[s] = 0; m_have_hi[s] = 0;
      m_ptr[s] = 0; m_count[s] = 0; m_ovf[s] = 0;
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input int s, input logic [7:0] b);
    if (s == 0) begin rx_data_b = b; rx_valid_b = 1'b1; end
    else        begin rx_data_s = b; rx_valid_s = 1'b1; end
    @(negedge clk);
    rx_valid_b = 1'b0; rx_valid_s = 1'b0;
    model_byte(s, b);
  endtask

  task automatic send_word(input int s, input logic [15:0] w, input int gap);
    send_byte(s, w[15:8]);
    repeat (gap) @(negedge clk);
    send_byte(s, w[7:0]);
    repeat (gap) @(negedge clk);
  endtask

  task automatic read_word(input int s, input int a, output logic [15:0] v);
    if (s == 0) addr_b = 11'(a); else addr_s = 2'(a);
    @(negedge clk);
    v = (s == 0) ? instr_b : instr_s;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset(0); model_reset(1);
  endtask

  task automatic test_reset();
    do_reset(2);
    total++; if (cpurst_b !== 1'b1) begin bad++; $display("FAIL reset_cpureset got=%b exp=1", cpurst_b); end
    total++; if (run_b !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", run_b); end
    total++; if (wc_b !== 12'd0) begin bad++; $display("FAIL reset_wordcount got=%0d exp=0", wc_b); end
    total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", ovf_b); end
    total++; if (instr_b !== 16'h0000) begin bad++; $display("FAIL reset_instruction got=%h exp=0000", instr_b); end
    total++; if (cpurst_s !== 1'b1 || wc_s !== 3'd0) begin bad++; $display("FAIL reset_small got=%b/%0d exp=1/0", cpurst_s, wc_s); end
  endtask

  task automatic test_basic_load();
    logic [7:0]  seq [9] = '{8'h12, 8'h34, 8'hA5, 8'h08, 8'h01, 8'h10, 8'h02, 8'h00, 8'h00};
    logic [15:0] v;
    foreach (seq[i]) begin
      send_byte(0, seq[i]);
      if (i < 8) @(negedge clk);
    end
    total++; if (run_b !== m_running[0] || cpurst_b !== !m_running[0]) begin bad++; $display("FAIL basic_run got=%b/%b exp=%b/%b", run_b, cpurst_b, m_running[0], !m_running[0]); end
    total++; if (wc_b !== 12'(m_count[0])) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", wc_b, m_count[0]); end
    for (int a = 0; a < 3; a++) begin
      read_word(0, a, v);
      total++; if (v !== m_mem[0][a]) begin bad++; $display("FAIL basic_mem[%0d] got=%h exp=%h", a, v, m_mem[0][a]); end
    end
    read_word(0, 1, v);
    total++; if (v !== 16'h1002) begin bad++; $display("FAIL basic_addr1 got=%h exp=1002", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  seq [5] = '{8'hA5, 8'h08, 8'h01, 8'h00, 8'h00};
    logic [15:0] v;
    do_reset(1);
    foreach (seq[i]) send_byte(0, seq[i]);
    total++; if (run_b !== 1'b1 || !m_running[0]) begin bad++; $display("FAIL b2b_run got=%b exp=1", run_b); end
    total++; if (wc_b !== 12'(m_count[0])) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", wc_b, m_count[0]); end
    read_word(0, 0, v);
    total++; if (v !== m_mem[0][0]) begin bad++; $display("FAIL b2b_mem0 got=%h exp=%h", v, m_mem[0][0]); end
  endtask

  task automatic test_overflow(input logic [15:0] last_word, input bit use_reload);
    logic [15:0] v;
    if (use_reload) send_byte(1, 8'hC3);
    else begin do_reset(1); send_byte(1, 8'hA5); end
    for (int i = 1; i <= 3; i++) send_word(1, 16'(i), i - 1);
    send_word(1, last_word, 0);
    total++; if (run_s !== m_running[1]) begin bad++; $display("FAIL ovf_run word=%h got=%b exp=%b", last_word, run_s, m_running[1]); end
    total++; if (ovf_s !== m_ovf[1]) begin bad++; $display("FAIL ovf_flag word=%h got=%b exp=%b", last_word, ovf_s, m_ovf[1]); end
    total++; if (wc_s !== 3'(m_count[1])) begin bad++; $display("FAIL ovf_count word=%h got=%0d exp=%0d", last_word, wc_s, m_count[1]); end
    for (int a = 0; a < 4; a++) begin
      read_word(1, a, v);
      total++; if (v !== m_mem[1][a]) begin bad++; $display("FAIL ovf_mem[%0d] got=%h exp=%h", a, v, m_mem[1][a]); end
    end
  endtask

  task automatic test_reload();
    logic [15:0] v;
    do_reset(1);
    send_byte(0, 8'hA5);
    send_word(0, 16'h0801, 1);
    send_word(0, 16'h0000, 0);
    total++; if (run_b !== 1'b1) begin bad++; $display("FAIL reload_pre_run got=%b exp=1", run_b); end
    send_byte(0, 8'hC3);
    total++; if (cpurst_b !== 1'b1 || m_running[0]) begin bad++; $display("FAIL reload_cpureset got=%b exp=1", cpurst_b); end
    total++; if (wc_b !== 12'(m_count[0])) begin bad++; $display("FAIL reload_count got=%0d exp=%0d", wc_b, m_count[0]); end
    send_word(0, 16'h1805, 0);
    send_word(0, 16'h0000, 2);
    read_word(0, 0, v);
    total++; if (v !== 16'h1805 || v !== m_mem[0][0]) begin bad++; $display("FAIL reload_mem0 got=%h exp=1805", v); end
    total++; if (run_b !== m_running[0]) begin bad++; $display("FAIL reload_run got=%b exp=%b", run_b, m_running[0]); end
  endtask

  task automatic test_reset_midword();
    logic [15:0] v;
    logic [15:0] keep;
    keep = m_mem[0][0];
    send_byte(0, 8'hA5);
    send_byte(0, 8'h08);
    do_reset(1);
    send_byte(0, 8'h01);
    total++; if (cpurst_b !== 1'b1 || run_b !== 1'b0) begin bad++; $display("FAIL midreset_state got=%b/%b exp=1/0", cpurst_b, run_b); end
    total++; if (wc_b !== 12'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", wc_b); end
    read_word(0, 0, v);
    total++; if (v !== keep) begin bad++; $display("FAIL midreset_mem0 got=%h exp=%h", v, keep); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [7:0]  b;
    int          n;
    for (int it = 0; it < 6; it++) begin
      do_reset(1 + (it % 2));
      repeat ($urandom_range(0, 4)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(0, b);
      end
      send_byte(0, 8'hA5);
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) send_word(0, 16'($urandom_range(1, 65535)), $urandom_range(0, 2));
      send_word(0, 16'h0000, $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hC3) b = 8'h3C;
        send_byte(0, b);
      end
      total++; if (run_b !== m_running[0] || ovf_b !== m_ovf[0]) begin bad++; $display("FAIL rand%0d_status got=%b/%b exp=%b/%b", it, run_b, ovf_b, m_running[0], m_ovf[0]); end
      total++; if (wc_b !== 12'(m_count[0])) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wc_b, m_count[0]); end
      for (int a = 0; a < m_count[0]; a++) begin
        read_word(0, a, v);
        total++; if (v !== m_mem[0][a]) begin bad++; $display("FAIL rand%0d_mem[%0d] got=%h exp=%h", it, a, v, m_mem[0][a]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_overflow(16'h0004, 1'b0);
    test_overflow(16'h0000, 1'b1);
    test_reload();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
